mem_rd_arb: RTL and testbench
=============================

Name: mem_rd_arb

Overview:
- Read-side arbiter and sequencer for the memory farm SRAM port.
- Shares one SRAM read port between N_CLIENTS read clients: fcc, active, cnn_pic, cnn_wgt, pool (indices 0..4).
- Grants one burst at a time and generates the per-beat SRAM addresses. Routes returned read data to the owning client with a valid and last-beat marker.
- Selection uses a two-class priority set by client_priority, with round-robin inside each class.

Parameters:
- N_CLIENTS, 5, number of read requesters.
- ADDR_W, 19, SRAM word-address width.
- DATA_W, 128, SRAM read data width.
- LEN_W, 8, burst length field width; beats = len+1, so 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  N_CLIENTS  per-client burst request, level.
- addr_i  in  N_CLIENTS*ADDR_W  per-client start address; client k uses slice k.
- len_i  in  N_CLIENTS*LEN_W  per-client burst length minus 1.
- client_priority  in  N_CLIENTS  1 = client is in the high class.
- gnt_o  out  N_CLIENTS  one-hot, one-cycle acceptance pulse.
- rvalid_o  out  N_CLIENTS  one-hot, read data valid for the owner.
- rlast_o  out  1  marks the final returned beat of a burst.
- rdata_o  out  DATA_W  mem_rdata_i broadcast to all clients.
- mem_rd_o  out  1  SRAM read strobe.
- mem_addr_o  out  ADDR_W  SRAM word address.
- mem_ready_i  in  1  SRAM accepts the strobe this cycle.
- mem_rvalid_i  in  1  SRAM read data valid (in order, any latency).
- mem_rdata_i  in  DATA_W  SRAM read data.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky: mem_rvalid_i arrived with zero outstanding reads.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = N_CLIENTS-1; outstanding = 0; beat counters = 0. Reset wins over every other event.
- Reset mid-burst: return to IDLE immediately; any later mem_rvalid_i with zero outstanding sets err_o. Clients must re-request.
- FSM states: IDLE, BURST, DRAIN.
- IDLE, arbitration (combinational on registered state):
  - cand = req_i & client_priority if that is nonzero, else cand = req_i.
  - Winner = first set bit of cand searching from rr_ptr+1 upward, wrapping modulo N_CLIENTS.
  - If a winner exists: gnt_o[w]=1 for exactly this cycle; capture owner=w, cur_addr=addr_i[w], iss_left=len_i[w], ret_left=len_i[w]; rr_ptr<=w; go to BURST.
  - client_priority, addr_i and len_i are sampled only in the grant cycle.
- BURST:
  - mem_rd_o=1, mem_addr_o=cur_addr.
  - On mem_rd_o && mem_ready_i: cur_addr+1, wrapping modulo 2^ADDR_W (all-ones -> 0); outstanding+1.
  - If iss_left==0 on that handshake, go to DRAIN; otherwise iss_left-1.
  - mem_ready_i low: hold the strobe and address, no change.
- DRAIN: mem_rd_o=0. When outstanding==0 and no rvalid in the same cycle, go to IDLE. Earliest new grant is the cycle after IDLE is entered.
- Return path (BURST and DRAIN):
  - On mem_rvalid_i: rvalid_o[owner]=1 combinationally with rdata_o=mem_rdata_i; outstanding-1.
  - rlast_o=1 when ret_left==0; otherwise ret_left-1.
- Simultaneous issue and return in one cycle: outstanding unchanged.
- Same-cycle data return (zero latency) is legal.
- rvalid_o is all-zero in IDLE; unexpected rvalid sets err_o and is not forwarded.
- Requester drops req_i after its grant: the burst still completes. req_i is not re-checked after the grant.
- Requester holds req_i after its grant: it is re-arbitrated in the next IDLE, and the round-robin pointer gives other same-class requesters priority.
- Minimum per-burst overhead: 1 grant cycle plus 1 DRAIN cycle.
- Outstanding counter width: LEN_W+1, which cannot overflow since outstanding never exceeds len+1.

Test Plan:
- Single client, fixed latency: client 2 requests addr=0x100, len=3, RD_LAT=2, ready always high → gnt_o=5'b00100 once; mem_addr_o 0x100..0x103 on 4 consecutive cycles; 4 rvalid_o[2] pulses, rlast_o on the 4th; busy_o falls after DRAIN.
- Round-robin: clients 0, 1, 3 request continuously, len=0, client_priority=0 → grants go 0,1,3,0,1,3 and never repeat a client while others wait.
- Priority class: req_i=5'b11111, client_priority=5'b01000 → client 3 wins every arbitration. When client_priority=0, the order returns to round-robin starting after 3.
- Backpressure and wrap: addr=0x7FFFE, len=3, mem_ready_i toggling 1,0,1,0… → addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001, each held while ready is low; exactly 4 reads issued.
- Reset mid-burst: assert rst after 2 of 8 beats are issued → next cycle all outputs 0, state IDLE. Two stale mem_rvalid_i afterwards → err_o=1, no rvalid_o.
- Simultaneous issue and return: len=7, RD_LAT=0 → outstanding never exceeds 1; 8 rlast-terminated beats delivered; DRAIN lasts 1 cycle.

Source files
------------

// File: rtl/mem_rd_arb_if.sv
// Read-port bundle between the SRAM read clients, the arbiter and the SRAM.
// The arbiter takes the slave view; the client/SRAM side takes the master view.
interface mem_rd_arb_if #(
  parameter int N_CLIENTS = 5,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 8
);
  logic [N_CLIENTS-1:0]        req_i;
  logic [N_CLIENTS*ADDR_W-1:0] addr_i;
  logic [N_CLIENTS*LEN_W-1:0]  len_i;
  logic [N_CLIENTS-1:0]        client_priority;
  logic [N_CLIENTS-1:0]        gnt_o;
  logic [N_CLIENTS-1:0]        rvalid_o;
  logic                        rlast_o;
  logic [DATA_W-1:0]           rdata_o;
  logic                        mem_rd_o;
  logic [ADDR_W-1:0]           mem_addr_o;
  logic                        mem_ready_i;
  logic                        mem_rvalid_i;
  logic [DATA_W-1:0]           mem_rdata_i;
  logic                        busy_o;
  logic                        err_o;

  modport slave (
    input  req_i, addr_i, len_i, client_priority,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, rvalid_o, rlast_o, rdata_o,
    output mem_rd_o, mem_addr_o, busy_o, err_o
  );

  modport master (
    output req_i, addr_i, len_i, client_priority,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rlast_o, rdata_o,
    input  mem_rd_o, mem_addr_o, busy_o, err_o
  );
endinterface

// File: rtl/mem_rd_arb.sv
// Memory farm SRAM read arbiter: two-class round-robin burst grant,
// per-beat address sequencing and in-order return routing to the owner.
module mem_rd_arb #(
  parameter int N_CLIENTS = 5,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 8
) (
  input logic         clk,
  input logic         rst,
  mem_rd_arb_if.slave bus
);
  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CW = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        win;
  logic                 win_vld;
  logic [N_CLIENTS-1:0] hi;
  logic [N_CLIENTS-1:0] cand;
  logic [ADDR_W-1:0]    cur_addr;
  logic [LEN_W-1:0]     iss_left;
  logic [LEN_W-1:0]     ret_left;
  logic [CW-1:0]        outstanding;
  logic                 err;
  logic                 rd_en;
  logic                 issue;
  logic                 rv_ok;
  logic [DATA_W-1:0]    rdata;

  // Pick the next owner: high class first, round-robin after rr_ptr.
  always_comb begin
    hi      = bus.req_i & bus.client_priority;
    cand    = (hi != '0) ? hi : bus.req_i;
    win_vld = 1'b0;
    win     = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      if (!win_vld &&
          cand[IW'((int'(rr_ptr) + k) % N_CLIENTS)]) begin
        win_vld = 1'b1;
        win     = IW'((int'(rr_ptr) + k) % N_CLIENTS);
      end
    end
  end

  // A return is legal only against an in-flight or same-cycle read.
  assign rd_en = (state == BURST) && !rst;
  assign issue = rd_en && bus.mem_ready_i;
  assign rv_ok = bus.mem_rvalid_i && !rst &&
                 (state != IDLE) &&
                 ((outstanding != '0) || issue);
  assign rdata = bus.mem_rdata_i;

  assign bus.gnt_o =
    ((state == IDLE) && win_vld && !rst) ?
    (N_CLIENTS'(1) << win) : '0;
  assign bus.mem_rd_o   = rd_en;
  assign bus.mem_addr_o = rd_en ? cur_addr : '0;
  assign bus.rvalid_o   =
    rv_ok ? (N_CLIENTS'(1) << owner) : '0;
  assign bus.rlast_o    = rv_ok && (ret_left == '0);
  assign bus.rdata_o    = rdata;
  assign bus.busy_o     = (state != IDLE) && !rst;
  assign bus.err_o      = err;

  // Next-state: grant, issue all beats, then wait for returns.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (win_vld) state_nxt = BURST;
      end
      BURST: begin
        if (issue && (iss_left == '0))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((outstanding == '0) && !bus.mem_rvalid_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Burst bookkeeping: owner capture, address/beat counters, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= IW'(N_CLIENTS - 1);
      owner       <= '0;
      cur_addr    <= '0;
      iss_left    <= '0;
      ret_left    <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if ((state == IDLE) && win_vld) begin
        owner    <= win;
        rr_ptr   <= win;
        cur_addr <= bus.addr_i[int'(win)*ADDR_W +: ADDR_W];
        iss_left <= bus.len_i[int'(win)*LEN_W +: LEN_W];
        ret_left <= bus.len_i[int'(win)*LEN_W +: LEN_W];
      end
      if (issue) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        if (iss_left != '0)
          iss_left <= iss_left - LEN_W'(1);
      end
      if (rv_ok && (ret_left != '0))
        ret_left <= ret_left - LEN_W'(1);
      if (issue && !rv_ok)
        outstanding <= outstanding + CW'(1);
      else if (!issue && rv_ok)
        outstanding <= outstanding - CW'(1);
      if (bus.mem_rvalid_i && !rv_ok)
        err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_rd_arb.sv
// Bench for mem_rd_arb: queue-based burst model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_rd_arb;
  localparam int N  = 5;
  localparam int AW = 19;
  localparam int DW = 128;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_rd_arb_if #(
    .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) bus ();

  mem_rd_arb #(
    .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // SRAM model: fixed read latency, data derived from the address.
  function automatic logic [DW-1:0] dat(logic [AW-1:0] a);
    return {9'h1a5, {6{a}}, 5'h0};
  endfunction

  int            rd_lat = 1;
  bit            tog = 0;
  logic [7:0]    pv = '0;
  logic [AW-1:0] pa [8];
  logic          hs;
  logic          rv_raw;
  logic [AW-1:0] ra;

  assign hs = bus.mem_rd_o & bus.mem_ready_i;

  always @(posedge clk) begin
    pv    <= {pv[6:0], hs};
    pa[0] <= bus.mem_addr_o;
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
  end

  always_comb begin
    rv_raw = 1'b0;
    ra     = '0;
    if (rd_lat == 0) begin
      rv_raw = hs;
      ra     = bus.mem_addr_o;
    end else begin
      rv_raw = pv[rd_lat-1];
      ra     = pa[rd_lat-1];
    end
    bus.mem_rvalid_i = rv_raw;
    bus.mem_rdata_i  = rv_raw ? dat(ra) : '0;
  end

  initial begin
    bus.mem_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready_i = tog ? ~bus.mem_ready_i : 1'b1;
    end
  end

  // Model: a granted burst is a queue of beat addresses to issue and a
  // queue of issued-but-unreturned addresses.
  bit            m_act = 0;
  int            m_last = N - 1;
  int            m_owner = 0;
  int            m_beats = 0;
  int            m_nret = 0;
  bit            m_err = 0;
  logic [AW-1:0] m_iss [$];
  logic [AW-1:0] m_ret [$];

  int            gnt_log [$];
  logic [AW-1:0] iss_log [$];
  int            iss_cyc [$];
  int            rlast_at [$];
  int            rv_n = 0;
  int            drain_n = 0;
  int            cyc = 0;

  logic [N-1:0]  c_req, c_hi, c_cand;
  logic [N-1:0]  e_gnt, e_rv;
  logic [AW-1:0] e_addr, a0;
  logic [DW-1:0] e_dat;
  bit            e_rd, e_hs, e_ok, e_last, dx;
  int            ew, j;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      c_req = bus.req_i;
      ew = -1;
      if (!rst && !m_act) begin
        c_hi   = c_req & bus.client_priority;
        c_cand = (c_hi != '0) ? c_hi : c_req;
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (ew < 0 && c_cand[j]) ew = j;
        end
      end
      e_gnt  = (ew >= 0) ? (N'(1) << ew) : '0;
      e_rd   = !rst && m_act && (m_iss.size() > 0);
      e_addr = e_rd ? m_iss[0] : '0;
      e_hs   = e_rd && bus.mem_ready_i;
      e_ok   = !rst && m_act && bus.mem_rvalid_i &&
               (m_ret.size() > 0 || e_hs);
      e_rv   = e_ok ? (N'(1) << m_owner) : '0;
      e_last = e_ok && (m_nret == m_beats - 1);
      e_dat  = (m_ret.size() > 0) ? dat(m_ret[0]) : dat(e_addr);

      chk("gnt", bus.gnt_o, e_gnt);
      chk("mem_rd", bus.mem_rd_o, e_rd);
      chk("mem_addr", bus.mem_addr_o, e_addr);
      chk("rvalid", bus.rvalid_o, e_rv);
      chk("rlast", bus.rlast_o, e_last);
      chk("busy", bus.busy_o, !rst && m_act);
      chk("err", bus.err_o, m_err);
      chk("rdata_bcast", bus.rdata_o, bus.mem_rdata_i);
      if (e_ok) chk("rdata_beat", bus.rdata_o, e_dat);

      for (int i = 0; i < N; i++)
        if (bus.gnt_o[i]) gnt_log.push_back(i);
      if (hs) begin
        iss_log.push_back(bus.mem_addr_o);
        iss_cyc.push_back(cyc);
      end
      if (bus.rvalid_o != '0) begin
        if (bus.rlast_o) rlast_at.push_back(rv_n);
        rv_n++;
      end
      if (bus.busy_o && !bus.mem_rd_o) drain_n++;

      if (rst) begin
        m_act  = 0;
        m_last = N - 1;
        m_err  = 0;
        m_iss.delete();
        m_ret.delete();
      end else if (!m_act) begin
        if (bus.mem_rvalid_i) m_err = 1;
        if (ew >= 0) begin
          m_act   = 1;
          m_owner = ew;
          m_last  = ew;
          m_nret  = 0;
          m_beats = int'(bus.len_i[ew*LW +: LW]) + 1;
          a0      = bus.addr_i[ew*AW +: AW];
          for (int i = 0; i < m_beats; i++)
            m_iss.push_back(AW'(int'(a0) + i));
        end
      end else begin
        dx = (m_iss.size() == 0) && (m_ret.size() == 0) &&
             !bus.mem_rvalid_i;
        if (e_hs) m_ret.push_back(m_iss.pop_front());
        if (e_ok) begin
          void'(m_ret.pop_front());
          m_nret++;
        end else if (bus.mem_rvalid_i) begin
          m_err = 1;
        end
        if (dx) m_act = 0;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(int k, logic [AW-1:0] a, logic [LW-1:0] l);
    bus.addr_i[k*AW +: AW] = a;
    bus.len_i[k*LW +: LW]  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    tick(2);
    rst = 1'b0;
    gnt_log.delete();
    iss_log.delete();
    iss_cyc.delete();
    rlast_at.delete();
    rv_n = 0;
    drain_n = 0;
    #1;
  endtask

  task automatic wait_gnts(int n, int lim);
    int c = 0;
    while (gnt_log.size() < n && c < lim) begin
      tick(1);
      c++;
    end
    chk("gnt_wait", gnt_log.size() >= n, 1);
  endtask

  task automatic wait_idle(int lim);
    int c = 0;
    tick(1);
    while (bus.busy_o && c < lim) begin
      tick(1);
      c++;
    end
    chk("idle_wait", bus.busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req_i = '0;
    bus.addr_i = '0;
    bus.len_i = '0;
    bus.client_priority = '0;

    // Reset state
    do_reset();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_rd", bus.mem_rd_o, 0);
    chk("rst_err", bus.err_o, 0);

    // Single client, latency 2
    rd_lat = 2;
    cfg(2, 19'h00100, 8'd3);
    bus.req_i = 5'b00100;
    wait_gnts(1, 20);
    bus.req_i = '0;
    wait_idle(40);
    chk("t1_ngnt", gnt_log.size(), 1);
    chk("t1_gnt", gnt_log[0], 2);
    chk("t1_niss", iss_log.size(), 4);
    chk("t1_a0", iss_log[0], 19'h00100);
    chk("t1_a3", iss_log[3], 19'h00103);
    chk("t1_span", iss_cyc[3] - iss_cyc[0], 3);
    chk("t1_nrv", rv_n, 4);
    chk("t1_rlast", rlast_at[0], 3);

    // Round-robin among 0,1,3
    do_reset();
    rd_lat = 1;
    for (int k = 0; k < N; k++) cfg(k, AW'(k * 16), 8'd0);
    bus.req_i = 5'b01011;
    wait_gnts(6, 60);
    bus.req_i = '0;
    wait_idle(20);
    chk("rr_g0", gnt_log[0], 0);
    chk("rr_g1", gnt_log[1], 1);
    chk("rr_g2", gnt_log[2], 3);
    chk("rr_g3", gnt_log[3], 0);
    chk("rr_g5", gnt_log[5], 3);

    // Priority class, then back to round-robin
    do_reset();
    bus.req_i = 5'b11111;
    bus.client_priority = 5'b01000;
    wait_gnts(3, 40);
    bus.client_priority = '0;
    wait_gnts(7, 60);
    bus.req_i = '0;
    wait_idle(20);
    chk("pr_g0", gnt_log[0], 3);
    chk("pr_g2", gnt_log[2], 3);
    chk("pr_g3", gnt_log[3], 4);
    chk("pr_g4", gnt_log[4], 0);
    chk("pr_g6", gnt_log[6], 2);

    // Backpressure and address wrap
    do_reset();
    tog = 1;
    cfg(0, 19'h7fffe, 8'd3);
    bus.req_i = 5'b00001;
    wait_gnts(1, 20);
    bus.req_i = '0;
    wait_idle(40);
    tog = 0;
    chk("bp_niss", iss_log.size(), 4);
    chk("bp_a1", iss_log[1], 19'h7ffff);
    chk("bp_a2", iss_log[2], 19'h00000);
    chk("bp_a3", iss_log[3], 19'h00001);
    chk("bp_span", iss_cyc[3] - iss_cyc[0], 6);
    chk("bp_nrv", rv_n, 4);

    // Reset mid-burst, stale returns afterwards
    do_reset();
    rd_lat = 4;
    cfg(1, 19'h00020, 8'd7);
    bus.req_i = 5'b00010;
    begin
      int c = 0;
      while (iss_log.size() < 2 && c < 20) begin
        tick(1);
        c++;
      end
    end
    chk("mr_two", iss_log.size(), 2);
    rst = 1'b1;
    bus.req_i = '0;
    tick(1);
    rst = 1'b0;
    #1;
    chk("mr_busy", bus.busy_o, 0);
    chk("mr_rd", bus.mem_rd_o, 0);
    chk("mr_addr", bus.mem_addr_o, 0);
    chk("mr_gnt", bus.gnt_o, 0);
    chk("mr_err0", bus.err_o, 0);
    tick(4);
    chk("mr_err1", bus.err_o, 1);
    chk("mr_nrv", rv_n, 0);
    chk("mr_niss", iss_log.size(), 2);

    // Zero-latency return, issue and return together
    do_reset();
    rd_lat = 0;
    cfg(4, 19'h00040, 8'd7);
    bus.req_i = 5'b10000;
    wait_gnts(1, 20);
    bus.req_i = '0;
    wait_idle(40);
    chk("z_niss", iss_log.size(), 8);
    chk("z_a7", iss_log[7], 19'h00047);
    chk("z_nrv", rv_n, 8);
    chk("z_rlast", rlast_at[0], 7);
    chk("z_nlast", rlast_at.size(), 1);
    chk("z_drain", drain_n, 1);
    chk("z_err", bus.err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
